mem_rsp_ram: RTL
================

# mem_rsp_ram

Synthesizable single-port RAM with a valid/ready request channel, byte-enabled writes, configurable read pipeline latency, and a credit-controlled response buffer. It replaces the behavioural task-based memory model as the shared on-chip storage used by benches and datapath blocks. It adds an optional zero-fill sweep after reset and out-of-range error reporting for non-power-of-two sizes.

## Interface
Parameters:
- `DATA_WIDTH`, 32: word width in bits; must be a multiple of 8.
- `SIZE`, 1024: number of words; need not be a power of two.
- `READ_LATENCY`, 2: accept-to-response cycles; legal range 1..4.
- `CLEAR_ON_RESET`, 1: when 1, zero-fill all words after reset before accepting requests.

Ports:
- `clk` input 1: single clock; all logic is on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: request accepted on the edge where `req_valid && req_ready`.
- `req_write` input 1: 1 = write, 0 = read.
- `req_addr` input `$clog2(SIZE)`: word address.
- `req_wdata` input `DATA_WIDTH`: write data.
- `req_be` input `DATA_WIDTH/8`: byte enables; bit i covers byte i. Ignored on reads.
- `rsp_valid` output 1: response present.
- `rsp_ready` input 1: response consumed on the edge where `rsp_valid && rsp_ready`.
- `rsp_rdata` output `DATA_WIDTH`: read data. It is 0 for write responses and error responses.
- `rsp_error` output 1: the request address was ≥ `SIZE`.
- `init_done` output 1: the zero-fill sweep is complete and requests may be accepted.

## Operation
- **State machine:** `INIT` → `RUN`.
  - `rst` forces `INIT` with the fill address at 0.
  - In `INIT`, when `CLEAR_ON_RESET` = 1, the block writes 0 to one word per cycle, addresses 0..`SIZE`-1. It moves to `RUN` after `SIZE`-1 has been written.
  - When `CLEAR_ON_RESET` = 0, `INIT` lasts exactly one cycle.
- **Response count:** every accepted request, read or write, produces exactly one response, in acceptance order.
- **Writes:** only enabled bytes are updated, on the acceptance edge.
- **Reads:** `rsp_rdata` returns the word as it stands after any write accepted in an earlier cycle. Read-after-write on consecutive cycles returns the new data.
- **Out-of-range addresses:** when `req_addr` ≥ `SIZE`, memory is not modified, `rsp_error` = 1 and `rsp_rdata` = 0.
- **Response buffer:** depth D = `READ_LATENCY` + 1.
  - A credit counter, `$clog2(D+1)` bits, tracks in-flight plus buffered responses.
  - The counter increments on request accept and decrements on response pop. Accept and pop in the same cycle leave it unchanged.
- **Request ready:** `req_ready` = (state == `RUN`) && (count < D). It does not depend on `req_valid`.
- **`rsp_ready` low:** the buffer holds responses. Nothing is dropped and nothing is overwritten.
- **Reset mid-operation:**
  - All pipeline stages, buffered responses and credits are cleared, and the responses are lost.
  - Memory is re-zeroed if `CLEAR_ON_RESET` = 1, and retained otherwise.
  - Reset during `INIT` restarts the sweep from address 0.

## Timing
- **Output values during and after reset:** `req_ready` = 0, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_error` = 0, `init_done` = 0.
- **End of `INIT`:**
  - With `CLEAR_ON_RESET` = 1: `init_done` and `req_ready` first go high `SIZE` + 1 cycles after the edge where `rst` was sampled low.
  - With `CLEAR_ON_RESET` = 0: they go high after 1 cycle.
- **Response latency:** a request accepted at edge T with an empty buffer gives `rsp_valid` = 1 during the cycle after edge T + `READ_LATENCY` - 1. That is `READ_LATENCY` cycles of latency, and the response is visible for one cycle if `rsp_ready` = 1.
- **Throughput:** with `rsp_ready` held high, one request is accepted and one response is delivered every cycle.
- **Response stability:** `rsp_rdata` and `rsp_error` are held stable while `rsp_valid` && !`rsp_ready`.
- **Output timing path:** `req_ready` is registered or derived from registered state only. There is no combinational path from `rsp_ready` to `req_ready`.

## Structure
- **Package `mem_rsp_pkg`:**
  - A parametrised class or typedef helper for address, data and byte-enable widths.
  - A state enum `{INIT, RUN}`.
  - A response struct `{rdata, error}`.
  - A function `max_latency() = 4`.
- **Sub-module `mem_rsp_fifo`:**
  - Depth D, carrying the response struct.
  - Count, full and empty flags.
  - Synchronous active-high reset.
- **Top level:** the memory array, the `INIT` sweep, the `READ_LATENCY`-stage read pipeline and the credit counter live in `mem_rsp_ram`.

## Test plan
All scenarios use `DATA_WIDTH` = 32, `SIZE` = 1000, `READ_LATENCY` = 2 unless stated otherwise.
- **Reset fill:** with `CLEAR_ON_RESET` = 1, release reset → `init_done` rises after 1001 cycles. Then read address 999 → `rsp_rdata` = 0x00000000 and `rsp_error` = 0, 2 cycles after accept.
- **Back-to-back write/read:** write 0x98798798 to 0x034 with be = 0xF, then read 0x034 on the next cycle → `rsp_rdata` = 0x98798798. The write response (rdata 0) arrives first.
- **Byte enables:** write 0x11223344 with be = 0xF to 0x010, then 0xAABBCCDD with be = 0x5, then read 0x010 → 0x11BB33DD.
- **Out of range:** write 0xFFFFFFFF to 1000, then read 1000 → both responses have `rsp_error` = 1 and `rsp_rdata` = 0. A read of 999 is unchanged.
- **Backpressure:** hold `rsp_ready` = 0 and issue 5 reads → exactly 3 are accepted, then `req_ready` = 0. Raise `rsp_ready` → the 3 responses drain in order with no loss, and `req_ready` returns.
- **Reset mid-operation:**
  - Assert `rst` for one cycle while 2 reads are in flight → no response is delivered and `init_done` = 0.
  - Assert `rst` again at fill address 500 → the sweep restarts from address 0 and lasts 1000 more cycles.

Source files
------------

// File: rtl/mem_rsp_pkg.sv
// mem_rsp_pkg: shared types and helpers for the mem_rsp_ram memory block
package mem_rsp_pkg;
  typedef enum logic {INIT, RUN} state_e;
  function automatic int max_latency();
    return 4;
  endfunction
  function automatic int be_w(int dw);
    return dw / 8;
  endfunction
endpackage

// File: rtl/mem_rsp_fifo.sv
// mem_rsp_fifo: response buffer of arbitrary depth carrying a response struct
module mem_rsp_fifo #(
  parameter int DEPTH = 3,
  parameter type T = logic [7:0]
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic full,
  output logic empty
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  T mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic do_push, do_pop;
  // depth need not be a power of two, so pointers wrap explicitly
  function automatic logic [PW-1:0] nxt(logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rp];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp <= nxt(wp);
      end
      if (do_pop) rp <= nxt(rp);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/mem_rsp_ram.sv
// mem_rsp_ram: single-port RAM with valid/ready requests, byte-enabled writes,
// fixed read latency and a credit-controlled response buffer
module mem_rsp_ram
  import mem_rsp_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SIZE = 1024,
  parameter int READ_LATENCY = 2,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  output logic req_ready,
  input  logic req_write,
  input  logic [$clog2(SIZE)-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic rsp_valid,
  input  logic rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic rsp_error,
  output logic init_done
);
  localparam int AW = $clog2(SIZE);
  localparam int BW = be_w(DATA_WIDTH);
  localparam int D = READ_LATENCY + 1;
  localparam int CW = $clog2(D + 1);
  localparam logic [AW:0] SZ = (AW + 1)'(SIZE);
  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic error;
  } rsp_t;
  state_e state;
  logic [AW:0] fill;
  logic [CW-1:0] cred, fcount;
  logic [DATA_WIDTH-1:0] mem [SIZE];
  logic acc, pop, err, fill_we, push, ffull, fempty, unused_ok;
  rsp_t in_rsp, push_rsp, head;
  assign req_ready = state == RUN && cred < CW'(D);
  assign init_done = state == RUN;
  assign acc = req_valid && req_ready && !rst;
  assign pop = rsp_valid && rsp_ready;
  assign err = {1'b0, req_addr} >= SZ;
  assign fill_we = state == INIT && CLEAR_ON_RESET != 0 && fill != SZ && !rst;
  always_comb begin
    in_rsp.error = err;
    in_rsp.rdata = (req_write || err) ? '0 : mem[req_addr];
  end
  // the sweep finishes one cycle after the last word is cleared
  always_ff @(posedge clk)
    if (rst) begin
      state <= INIT;
      fill <= '0;
      cred <= '0;
    end else begin
      if (fill_we) fill <= fill + 1'b1;
      if (state == INIT && (CLEAR_ON_RESET == 0 || fill == SZ)) state <= RUN;
      cred <= cred + CW'(acc) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (fill_we) mem[fill[AW-1:0]] <= '0;
    else if (acc && req_write && !err)
      for (int i = 0; i < BW; i++)
        if (req_be[i]) mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
  // read data is captured at acceptance, then delayed to hit the buffer on time
  if (READ_LATENCY == 1) begin : g_l1
    assign push = acc;
    assign push_rsp = in_rsp;
  end else begin : g_pipe
    logic [READ_LATENCY-2:0] pv;
    rsp_t pd [READ_LATENCY-1];
    always_ff @(posedge clk) begin
      pv <= rst ? '0 : (READ_LATENCY - 1)'({pv, acc});
      pd[0] <= in_rsp;
      for (int i = 1; i < READ_LATENCY - 1; i++) pd[i] <= pd[i-1];
    end
    assign push = pv[READ_LATENCY-2];
    assign push_rsp = pd[READ_LATENCY-2];
  end
  mem_rsp_fifo #(.DEPTH(D), .T(rsp_t)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .din(push_rsp),
    .pop(pop),
    .dout(head),
    .count(fcount),
    .full(ffull),
    .empty(fempty)
  );
  assign rsp_valid = !fempty;
  assign rsp_rdata = fempty ? '0 : head.rdata;
  assign rsp_error = !fempty && head.error;
  assign unused_ok = ^{fcount, ffull};
endmodule
